up_dn_counter_ctrl: RTL

UP_DN_COUNTER_CTRL -- requirements
Module: up_dn_counter_ctrl

---
 rtl/up_dn_counter_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/up_dn_counter_ctrl.sv
// up_dn_counter_ctrl: command FSM that drives an external 5-bit up/down counter
// to a target value, either by stepping it (Mode=0) or by a direct load (Mode=1).
// Ports: CLK/RST (sync, active-high); Start/Mode/Target command inputs;
//   Counter_In/High_In/Low_In counter feedback; Cnt_Val/Load/Up/Down counter
//   controls; Busy/Done/Err status.
// Optional feature macro: UP_DN_STEP_DIV_EN. When it is defined, SETTLE lasts STEP_DIV
//   cycles. Otherwise SETTLE lasts one cycle and no settle counter is built.
module up_dn_counter_ctrl #(
  parameter int unsigned STEP_DIV  = 4,
  parameter int unsigned MAX_STEPS = 31
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Start,
  input  logic       Mode,
  input  logic [4:0] Target,
  input  logic [4:0] Counter_In,
  input  logic       High_In,
  input  logic       Low_In,
  output logic [4:0] Cnt_Val,
  output logic       Load,
  output logic       Up,
  output logic       Down,
  output logic       Busy,
  output logic       Done,
  output logic       Err
);

  // The step counter is sized so that it can hold MAX_STEPS itself.
  localparam int unsigned SW = (MAX_STEPS < 1) ? 1 : $clog2(MAX_STEPS + 1);

  // Catch illegal STEP_DIV values at elaboration.
  if (STEP_DIV < 1 || STEP_DIV > 15) begin : g_bad_step_div
    $error("up_dn_counter_ctrl: STEP_DIV must be in 1..15");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CMP,
    S_STEP_UP,
    S_STEP_DN,
    S_SETTLE,
    S_DONE,
    S_ERR
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [4:0]      tgt;
  logic [SW-1:0]   step_cnt;
  logic            settle_last;

`ifdef UP_DN_STEP_DIV_EN
  // The settle counter counts cycles spent in SETTLE. It is cleared whenever
  // the FSM is in any other state, so each visit to SETTLE starts at zero.
  logic [3:0] div_cnt;

  always_ff @(posedge CLK) begin
    if (RST || state != S_SETTLE) begin
      div_cnt <= 4'd0;
    end else begin
      div_cnt <= div_cnt + 4'd1;
    end
  end

  assign settle_last = (div_cnt == 4'(STEP_DIV - 1));
`else
  assign settle_last = 1'b1;
`endif

  // State, latched target and step count
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      tgt      <= 5'd0;
      step_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && Start) begin
        tgt      <= Target;
        step_cnt <= '0;
      end else if (state == S_STEP_UP || state == S_STEP_DN) begin
        step_cnt <= step_cnt + 1'b1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (Start) begin
          state_nxt = Mode ? S_LOAD : S_CMP;
        end
      end
      S_LOAD:    state_nxt = S_SETTLE;
      S_CMP: begin
        // Unsigned compare. The end-stop flags block any step that would
        // wrap the counter past 0 or 31.
        if (Counter_In == tgt) begin
          state_nxt = S_DONE;
        end else if (Counter_In < tgt && !High_In) begin
          state_nxt = S_STEP_UP;
        end else if (Counter_In > tgt && !Low_In) begin
          state_nxt = S_STEP_DN;
        end else begin
          state_nxt = S_ERR;
        end
      end
      S_STEP_UP: state_nxt = S_SETTLE;
      S_STEP_DN: state_nxt = S_SETTLE;
      S_SETTLE: begin
        if (settle_last) begin
          // When the step budget is spent and the target is still missed,
          // the command aborts. A counter that never moves lands here.
          if (step_cnt == SW'(MAX_STEPS) && Counter_In != tgt) begin
            state_nxt = S_ERR;
          end else begin
            state_nxt = S_CMP;
          end
        end
      end
      S_DONE:    state_nxt = S_IDLE;
      S_ERR:     state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs. Each strobe is decoded from a single state, so at most one
  // strobe is high per cycle. SETTLE always separates two steps, so Up and
  // Down are never high in back-to-back cycles.
  always_comb begin
    Cnt_Val = tgt;
    Load    = (state == S_LOAD);
    Up      = (state == S_STEP_UP);
    Down    = (state == S_STEP_DN);
    Busy    = (state != S_IDLE);
    Done    = (state == S_DONE);
    Err     = (state == S_ERR);
  end

endmodule
